sao_pip_ctrl: RTL

CTU-level sequencer for the SAO statistics pipeline. It walks the picture in raster CTU order and steps the statistics stage through luma, Cb and Cr. Once all three components of a CTU are collected and the decision stage is ready, it fires the one-cycle pass strobe that moves the statistics into the decision-stage pipeline registers. It drives the control inputs of the stage-1-to-stage-2 pipeline register (en, cIdx, end_of_*_st, ctu_x/ctu_y, merge availability, able_to_pass).

---
 rtl/sao_pip_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sao_pip_ctrl.sv
// CTU-level sequencer for the SAO statistics pipeline: walks CTUs in raster
// order, steps Y/Cb/Cr statistics collection and strobes the stage-1-to-2 pass.
module sao_pip_ctrl #(
  parameter int ctu_x_len = 9,
  parameter int ctu_y_len = 9
) (
  input  logic                 clk_slow,
  input  logic                 arst_n,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ctu_x_len-1:0] pic_w_ctu,
  input  logic [ctu_y_len-1:0] pic_h_ctu,
  input  logic                 st_done,
  input  logic                 dc_ready,
  output logic                 en,
  output logic [1:0]           cIdx,
  output logic                 end_of_luma_st,
  output logic                 end_of_chroma_st,
  output logic                 able_to_pass,
  output logic [ctu_x_len-1:0] ctu_x,
  output logic [ctu_y_len-1:0] ctu_y,
  output logic                 isLeftMergeAvail,
  output logic                 isUpperMergeAvail,
  output logic                 busy,
  output logic                 pic_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT_DC = 2'd2,
    PASS    = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ctu_x_len-1:0] ctu_x_r, ctu_x_nxt_s, pic_w_r, pic_w_nxt_s;
  logic [ctu_y_len-1:0] ctu_y_r, ctu_y_nxt_s, pic_h_r, pic_h_nxt_s;
  logic [1:0]           cidx_r, cidx_nxt_s;
  logic                 last_x_s, last_y_s;

  assign last_x_s = (ctu_x_r == (pic_w_r - ctu_x_len'(1)));
  assign last_y_s = (ctu_y_r == (pic_h_r - ctu_y_len'(1)));

  // Next-state, CTU position and component index sequencing.
  always_comb begin
    state_nxt_s = state_r;
    ctu_x_nxt_s = ctu_x_r;
    ctu_y_nxt_s = ctu_y_r;
    cidx_nxt_s  = cidx_r;
    pic_w_nxt_s = pic_w_r;
    pic_h_nxt_s = pic_h_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          // A zero dimension is clamped so the walk always covers at least one CTU.
          pic_w_nxt_s = (pic_w_ctu == {ctu_x_len{1'b0}}) ? ctu_x_len'(1) : pic_w_ctu;
          pic_h_nxt_s = (pic_h_ctu == {ctu_y_len{1'b0}}) ? ctu_y_len'(1) : pic_h_ctu;
          ctu_x_nxt_s = {ctu_x_len{1'b0}};
          ctu_y_nxt_s = {ctu_y_len{1'b0}};
          cidx_nxt_s  = 2'd0;
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (st_done) begin
          if (cidx_r == 2'd2) begin
            state_nxt_s = WAIT_DC;
          end else begin
            cidx_nxt_s = cidx_r + 2'd1;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      WAIT_DC: begin
        if (dc_ready) begin
          state_nxt_s = PASS;
        end else begin
          state_nxt_s = WAIT_DC;
        end
      end
      PASS: begin
        if (last_x_s && last_y_s) begin
          state_nxt_s = IDLE;
        end else begin
          if (last_x_s) begin
            ctu_x_nxt_s = {ctu_x_len{1'b0}};
            ctu_y_nxt_s = ctu_y_r + ctu_y_len'(1);
          end else begin
            ctu_x_nxt_s = ctu_x_r + ctu_x_len'(1);
          end
          cidx_nxt_s  = 2'd0;
          state_nxt_s = COLLECT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and position registers with async and sync resets.
  always_ff @(posedge clk_slow or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
      ctu_x_r <= {ctu_x_len{1'b0}};
      ctu_y_r <= {ctu_y_len{1'b0}};
      cidx_r  <= 2'd0;
      pic_w_r <= ctu_x_len'(1);
      pic_h_r <= ctu_y_len'(1);
    end else if (!rst_n) begin
      state_r <= IDLE;
      ctu_x_r <= {ctu_x_len{1'b0}};
      ctu_y_r <= {ctu_y_len{1'b0}};
      cidx_r  <= 2'd0;
      pic_w_r <= ctu_x_len'(1);
      pic_h_r <= ctu_y_len'(1);
    end else begin
      state_r <= state_nxt_s;
      ctu_x_r <= ctu_x_nxt_s;
      ctu_y_r <= ctu_y_nxt_s;
      cidx_r  <= cidx_nxt_s;
      pic_w_r <= pic_w_nxt_s;
      pic_h_r <= pic_h_nxt_s;
    end
  end

  assign en                = (state_r == COLLECT);
  assign busy              = (state_r != IDLE);
  assign able_to_pass      = (state_r == PASS);
  assign pic_done          = (state_r == PASS) && last_x_s && last_y_s;
  assign end_of_luma_st    = (state_r == COLLECT) && st_done && (cidx_r == 2'd0);
  assign end_of_chroma_st  = (state_r == COLLECT) && st_done && (cidx_r != 2'd0);
  assign cIdx              = cidx_r;
  assign ctu_x             = ctu_x_r;
  assign ctu_y             = ctu_y_r;
  assign isLeftMergeAvail  = (ctu_x_r != {ctu_x_len{1'b0}});
  assign isUpperMergeAvail = (ctu_y_r != {ctu_y_len{1'b0}});

endmodule
